imem_loader: RTL and testbench

Boot-time program loader: the write side of the instruction ROM that the pipeline's fetch stage reads. It accepts a byte stream over a valid/ready handshake: a word count, then little-endian instruction words, then an XOR checksum. It writes each assembled word into the 128 x 32 instruction memory. It holds the core in reset (`core_rstn` low) until a load completes with a matching checksum.

---
 rtl/imem_loader.sv | 143 ++++++++++++++
 tb/tb_imem_loader.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot-time loader: receives length, little-endian words and an XOR checksum over a
// byte handshake, writes the words into instruction memory and releases core reset.
module imem_loader #(
    parameter int DEPTH  = 128,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rstn,
    output logic              busy,
    output logic              done,
    output logic              error
);
    // One extra index bit lets a full-depth load reach N without wrapping.
    localparam int IDX_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
    } state_t;

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] idx_reg;
    logic [IDX_W-1:0] len_reg;
    logic [1:0]       byte_cnt_reg;
    logic [7:0]       csum_reg;
    logic             accept;
    logic             start_ok;
    logic             len_bad;
    logic             last_word;

    assign accept    = in_valid && in_ready;
    assign start_ok  = load_start && (state_reg == S_IDLE || state_reg == S_DONE || state_reg == S_ERR);
    assign len_bad   = (in_data == 8'd0) || (32'(in_data) > DEPTH);
    assign last_word = (idx_reg + IDX_W'(1)) == len_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE, S_DONE, S_ERR: begin
                if (load_start) state_next = S_LEN;
            end
            S_LEN: begin
                if (accept) state_next = len_bad ? S_ERR : S_DATA;
            end
            S_DATA: begin
                if (accept && byte_cnt_reg == 2'd3) state_next = S_WRITE;
            end
            S_WRITE: begin
                state_next = last_word ? S_CSUM : S_DATA;
            end
            S_CSUM: begin
                if (accept) state_next = (in_data == csum_reg) ? S_DONE : S_ERR;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Every control output is a pure decode of the current state.
    always_comb begin
        in_ready  = 1'b0;
        imem_we   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        core_rstn = 1'b0;
        case (state_reg)
            S_LEN, S_DATA, S_CSUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            S_WRITE: begin
                imem_we = 1'b1;
                busy    = 1'b1;
            end
            S_DONE: begin
                done      = 1'b1;
                core_rstn = 1'b1;
            end
            S_ERR: error = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_reg      <= '0;
            len_reg      <= '0;
            byte_cnt_reg <= '0;
            csum_reg     <= '0;
        end else if (start_ok) begin
            idx_reg      <= '0;
            byte_cnt_reg <= '0;
            csum_reg     <= '0;
        end else begin
            case (state_reg)
                S_LEN: begin
                    if (accept) len_reg <= IDX_W'(in_data);
                end
                S_DATA: begin
                    if (accept) begin
                        byte_cnt_reg <= byte_cnt_reg + 2'd1;
                        csum_reg     <= csum_reg ^ in_data;
                    end
                end
                S_WRITE: idx_reg <= idx_reg + IDX_W'(1);
                default: ;
            endcase
        end
    end

    assign imem_addr = idx_reg[ADDR_W-1:0];

    // Each byte lane captures its own byte, so the word is assembled in place.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    lane_reg <= '0;
                end else if (state_reg == S_DATA && accept && byte_cnt_reg == 2'(gi)) begin
                    lane_reg <= in_data;
                end
            end
            assign imem_wdata[8*gi +: 8] = lane_reg;
        end
    endgenerate

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of complete loads plus hand-written
// sequences for mid-load reset and a full-depth load with gaps.
`timescale 1ns/1ps
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, imem_we, core_rstn, busy, done, error;
    logic [6:0]  imem_addr;
    logic [31:0] imem_wdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t_first = 0;

    logic [6:0]  wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    typedef struct {
        logic [7:0]  len;
        int          nw;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [7:0]  csum;
        logic        exp_done;
        int          exp_writes;
        int          exp_lat;
    } vec_t;
    vec_t vecs[6];

    imem_loader #(.DEPTH(128), .ADDR_W(7)) dut (
        .clk(clk), .rst(rst), .load_start(load_start),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_rstn(core_rstn), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (imem_we) begin
            wr_addr_q.push_back(imem_addr);
            wr_data_q.push_back(imem_wdata);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_imem_we"}, imem_we, 0);
        chk({tag, "_imem_addr"}, imem_addr, 0);
        chk({tag, "_imem_wdata"}, imem_wdata, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_core_rstn"}, core_rstn, 0);
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle the byte transferred.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t = 0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        while (!in_ready && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_byte: in_ready stayed 0 for byte 0x%02h", b);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], $urandom_range(0, maxgap));
    endtask

    task automatic start_load();
        load_start = 1'b1;
        @(posedge clk);
        #1;
        load_start = 1'b0;
        t_first = cyc;
        chk("start_in_ready", in_ready, 1);
        chk("start_busy", busy, 1);
        chk("start_done_cleared", done, 0);
        chk("start_error_cleared", error, 0);
        chk("start_core_rstn", core_rstn, 0);
    endtask

    task automatic wait_outcome(output int lat);
        int t = 0;
        @(negedge clk);
        while (!(done || error) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!(done || error)) begin
            checks++;
            errors++;
            $display("FAIL wait_outcome: neither done nor error after %0d cycles", t);
        end
        lat = cyc - t_first;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] w128(input int i);
        logic [7:0] a, b, c;
        a = 8'(i);
        b = ~a;
        c = 8'(i * 7);
        return {a, b, c, 8'h5A};
    endfunction

    function automatic logic [7:0] xor_bytes(input logic [31:0] w);
        return w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
    endfunction

    initial begin
        int lat;
        logic [31:0] w;
        logic [7:0] cs;

        vecs[0] = '{8'h02, 2, 32'h00500093, 32'h00408193, 8'h91, 1'b1, 2, 12};
        vecs[1] = '{8'h02, 2, 32'h00500093, 32'h00408193, 8'h90, 1'b0, 2, 12};
        vecs[2] = '{8'h02, 2, 32'h00500093, 32'h00408193, 8'h91, 1'b1, 2, 12};
        vecs[3] = '{8'h00, 0, 32'h0,        32'h0,        8'h00, 1'b0, 0, 1};
        vecs[4] = '{8'h81, 0, 32'h0,        32'h0,        8'h00, 1'b0, 0, 1};
        vecs[5] = '{8'h01, 1, 32'hDEADBEEF, 32'h0,        8'h22, 1'b1, 1, 7};

        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("por");
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_in_ready", in_ready, 0);
        chk("idle_busy", busy, 0);
        $display("por: reset values checked");

        // Reset after 5 words of an 8-word load, with load_start and a byte also presented
        wr_addr_q.delete();
        wr_data_q.delete();
        start_load();
        send_byte(8'h08, 0);
        for (int i = 0; i < 5; i++) send_word(32'h1000_0000 + i, 0);
        rst = 1'b1;
        load_start = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h55;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("midrst");
        chk("midrst_writes", wr_addr_q.size(), 5);
        rst = 1'b0;
        load_start = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_idle_in_ready", in_ready, 0);
        chk("midrst_core_rstn", core_rstn, 0);
        $display("midrst: writes=%0d in_ready=%0b core_rstn=%0b", wr_addr_q.size(), in_ready, core_rstn);

        // Table of complete loads
        for (int v = 0; v < 6; v++) begin
            wr_addr_q.delete();
            wr_data_q.delete();
            start_load();
            send_byte(vecs[v].len, 0);
            for (int j = 0; j < vecs[v].nw; j++) send_word(j == 0 ? vecs[v].w0 : vecs[v].w1, 0);
            if (vecs[v].nw > 0) send_byte(vecs[v].csum, 0);
            wait_outcome(lat);
            chk($sformatf("vec%0d_done", v), done, vecs[v].exp_done);
            chk($sformatf("vec%0d_error", v), error, !vecs[v].exp_done);
            chk($sformatf("vec%0d_core_rstn", v), core_rstn, vecs[v].exp_done);
            chk($sformatf("vec%0d_busy", v), busy, 0);
            chk($sformatf("vec%0d_in_ready", v), in_ready, 0);
            chk($sformatf("vec%0d_latency", v), lat, vecs[v].exp_lat);
            chk($sformatf("vec%0d_nwrites", v), wr_addr_q.size(), vecs[v].exp_writes);
            for (int j = 0; j < vecs[v].exp_writes && j < wr_addr_q.size(); j++) begin
                chk($sformatf("vec%0d_addr%0d", v, j), wr_addr_q[j], j);
                chk($sformatf("vec%0d_data%0d", v, j), wr_data_q[j], j == 0 ? vecs[v].w0 : vecs[v].w1);
            end
            $display("vec %0d: len=0x%02h done=%0b error=%0b writes=%0d latency=%0d",
                     v, vecs[v].len, done, error, wr_addr_q.size(), lat);
        end

        // Full-depth load with random gaps and a stray load_start mid-stream
        wr_addr_q.delete();
        wr_data_q.delete();
        cs = 8'h00;
        start_load();
        send_byte(8'h80, 1);
        for (int i = 0; i < 128; i++) begin
            if (i == 40) begin
                load_start = 1'b1;
                @(posedge clk);
                #1;
                load_start = 1'b0;
                chk("stray_start_busy", busy, 1);
            end
            w = w128(i);
            cs = cs ^ xor_bytes(w);
            send_word(w, 2);
        end
        send_byte(cs, 1);
        wait_outcome(lat);
        chk("full_done", done, 1);
        chk("full_error", error, 0);
        chk("full_core_rstn", core_rstn, 1);
        chk("full_nwrites", wr_addr_q.size(), 128);
        for (int i = 0; i < 128 && i < wr_addr_q.size(); i++) begin
            chk($sformatf("full_addr%0d", i), wr_addr_q[i], i);
            chk($sformatf("full_data%0d", i), wr_data_q[i], w128(i));
        end
        if (wr_addr_q.size() > 0) chk("full_last_addr", wr_addr_q[wr_addr_q.size() - 1], 127);
        $display("full: writes=%0d done=%0b error=%0b csum=0x%02h", wr_addr_q.size(), done, error, cs);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
